rtc_bus_ctrl: RTL and testbench

Bus-side controller for the external RTC's multiplexed address/data port. It executes one complete write or read transaction per request from the user and timer state machines, which present `escribe`/`dir_out`/`dato_out` and wait for `fin`. It drives the RTC chip-select, read/write strobes, address/data select line and the 8-bit A/D bus. It returns a one-cycle `fin` pulse and, for reads, the captured byte.

---
 rtl/rtc_bus_pkg.sv | 32 +++
 rtl/rtc_phase_timer.sv | 32 +++
 rtl/rtc_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller:
// FSM encoding, operation type, default phase length and RTC register map.
package rtc_bus_pkg;

  localparam int unsigned PHASE_CYC_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_ON  = 3'd1,
    ST_ADDR_OFF = 3'd2,
    ST_DATA_ON  = 3'd3,
    ST_DATA_OFF = 3'd4,
    ST_DONE     = 3'd5
  } bus_state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } bus_op_e;

  localparam logic [7:0] RTC_REG_CMD    = 8'h00;
  localparam logic [7:0] RTC_REG_SEC    = 8'h21;
  localparam logic [7:0] RTC_REG_MIN    = 8'h22;
  localparam logic [7:0] RTC_REG_HOUR   = 8'h23;
  localparam logic [7:0] RTC_REG_DAY    = 8'h24;
  localparam logic [7:0] RTC_REG_MONTH  = 8'h25;
  localparam logic [7:0] RTC_REG_YEAR   = 8'h26;
  localparam logic [7:0] RTC_REG_TIMER0 = 8'h41;
  localparam logic [7:0] RTC_REG_TIMER1 = 8'h42;
  localparam logic [7:0] RTC_REG_TIMER2 = 8'h43;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that paces bus phases; the zero flag is registered
// so it can be used directly as the FSM's phase-complete condition.
module rtc_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Load, count down to zero and hold there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      cnt_r <= load_val;
      zero  <= (load_val == '0);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
      zero  <= (cnt_r == W'(1));
    end else begin
      cnt_r <= cnt_r;
      zero  <= 1'b1;
    end
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed A/D bus controller: one address phase plus one data phase
// per request, returning a one-cycle fin pulse and, for reads, the byte read.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC = PHASE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic       leer,
  input  logic [7:0] dir_in,
  input  logic [7:0] dato_in,
  output logic       fin,
  output logic [7:0] dato_leido,
  output logic       ocupado,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [7:0] PH_LAST = 8'(PHASE_CYC - 1);

  bus_state_e state_r;
  bus_op_e    op_r;
  logic [7:0] data_r;
  logic       tmr_load_s;
  logic [7:0] tmr_val_s;
  logic       tmr_zero_s;

  rtc_phase_timer #(.W(8)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Timer reload at every state change; DONE gets two cycles (settle + fin).
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = PH_LAST;
    case (state_r)
      ST_IDLE: begin
        tmr_load_s = escribe | leer;
      end
      ST_ADDR_ON, ST_ADDR_OFF, ST_DATA_ON: begin
        tmr_load_s = tmr_zero_s;
      end
      ST_DATA_OFF: begin
        tmr_load_s = tmr_zero_s;
        tmr_val_s  = 8'd1;
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  // Bus sequencer with all pin outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      op_r       <= OP_WRITE;
      data_r     <= 8'h00;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      ad         <= 1'b1;
      ad_out     <= 8'h00;
      ad_oe      <= 1'b0;
      fin        <= 1'b0;
      ocupado    <= 1'b0;
      dato_leido <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          fin <= 1'b0;
          if (escribe || leer) begin
            op_r    <= escribe ? OP_WRITE : OP_READ;
            data_r  <= dato_in;
            ad_out  <= dir_in;
            ad_oe   <= 1'b1;
            ad      <= 1'b0;
            cs_n    <= 1'b0;
            wr_n    <= 1'b0;
            ocupado <= 1'b1;
            state_r <= ST_ADDR_ON;
          end else begin
            ocupado <= 1'b0;
          end
        end
        ST_ADDR_ON: begin
          if (tmr_zero_s) begin
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            state_r <= ST_ADDR_OFF;
          end
        end
        ST_ADDR_OFF: begin
          if (tmr_zero_s) begin
            ad   <= 1'b1;
            cs_n <= 1'b0;
            if (op_r == OP_WRITE) begin
              wr_n   <= 1'b0;
              ad_oe  <= 1'b1;
              ad_out <= data_r;
            end else begin
              rd_n  <= 1'b0;
              ad_oe <= 1'b0;
            end
            state_r <= ST_DATA_ON;
          end
        end
        ST_DATA_ON: begin
          if (tmr_zero_s) begin
            // ad_in sampled here is the last cycle with rd_n low.
            if (op_r == OP_READ) begin
              dato_leido <= ad_in;
            end
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            ad_oe   <= 1'b0;
            state_r <= ST_DATA_OFF;
          end
        end
        ST_DATA_OFF: begin
          if (tmr_zero_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (tmr_zero_s) begin
            fin     <= 1'b0;
            ocupado <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            fin <= 1'b1;
          end
        end
        default: begin
          cs_n    <= 1'b1;
          rd_n    <= 1'b1;
          wr_n    <= 1'b1;
          ad_oe   <= 1'b0;
          fin     <= 1'b0;
          ocupado <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: cycle-by-cycle bus expectations derived
// from the phase timing, plus read capture, priority, abort and back-to-back.
module tb_rtc_bus_ctrl;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       reset, escribe, leer;
  logic [7:0] dir_in, dato_in, ad_in;
  logic       fin, ocupado, cs_n, rd_n, wr_n, ad, ad_oe;
  logic [7:0] dato_leido, ad_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hi_run = 0;
  int last_fin = 0;
  logic [7:0] exp_dato = 8'h00;

  rtc_bus_ctrl #(.PHASE_CYC(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .escribe    (escribe),
    .leer       (leer),
    .dir_in     (dir_in),
    .dato_in    (dato_in),
    .fin        (fin),
    .dato_leido (dato_leido),
    .ocupado    (ocupado),
    .cs_n       (cs_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .ad         (ad),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .ad_in      (ad_in)
  );

  always #5 clk = ~clk;

  // Cycle stamp and length of the current chip-select-high run.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hi_run <= (cs_n === 1'b1) ? hi_run + 1 : 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One transaction from the acceptance edge through the IDLE cycle after fin.
  task automatic run_txn(input logic is_wr, input logic both, input logic [7:0] addr,
                         input logic [7:0] data, input logic [7:0] rdval,
                         input logic keep, input logic chg, input logic b2b);
    logic [6:0] e_bus;
    logic [7:0] e_out;
    int ph;
    escribe = is_wr | both;
    leer    = ~is_wr | both;
    dir_in  = addr;
    dato_in = data;
    @(posedge clk);
    for (int i = 0; i <= 4*P+2; i++) begin
      @(negedge clk);
      ph = i / P;
      if (i < 4*P) begin
        e_bus[6]   = ~(ph == 0 || ph == 2);
        e_bus[5]   = ~(ph == 2 && !is_wr);
        e_bus[4]   = ~(ph == 0 || (ph == 2 && is_wr));
        e_bus[3]   = (ph >= 2);
        e_bus[2]   = (ph < 2) || (ph == 2 && is_wr);
        e_bus[1:0] = 2'b01;
      end else begin
        e_bus = {5'b11110, (i == 4*P+1), (i <= 4*P+1)};
      end
      e_out = (ph < 2) ? addr : data;
      check_eq("bus", {25'd0, cs_n, rd_n, wr_n, ad, ad_oe, fin, ocupado}, {25'd0, e_bus});
      if (e_bus[2]) check_eq("ad_out", {24'd0, ad_out}, {24'd0, e_out});
      if (!is_wr && i == 3*P) exp_dato = rdval;
      check_eq("dato_leido", {24'd0, dato_leido}, {24'd0, exp_dato});
      if (b2b && i == 0) check_eq("cs_gap", hi_run, P+3);
      if (i == 4*P+1) begin
        if (b2b) check_eq("fin_gap", cyc - last_fin, 4*P+3);
        last_fin = cyc;
        if (!keep) begin
          escribe = 1'b0;
          leer    = 1'b0;
        end
      end
      if (chg && i == 3) begin
        dir_in  = 8'h41;
        dato_in = ~data;
      end
      ad_in = (!is_wr && i >= 2*P && i < 3*P) ? rdval : 8'hA5;
    end
  endtask

  initial begin
    reset = 1'b1; escribe = 1'b0; leer = 1'b0;
    dir_in = 8'h00; dato_in = 8'h00; ad_in = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_bus", {25'd0, cs_n, rd_n, wr_n, ad, ad_oe, fin, ocupado}, 32'h78);
    check_eq("reset_ad_out", {24'd0, ad_out}, 32'h00);
    check_eq("reset_dato", {24'd0, dato_leido}, 32'h00);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 1'b0, 8'h22, 8'h45, 8'h00, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b0, 8'h23, 8'h99, 8'h17, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b1, 8'h00, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);

    // Abort a write in DATA_ON with reset.
    escribe = 1'b1; dir_in = 8'h25; dato_in = 8'h12;
    @(posedge clk);
    repeat (2*P+3) @(negedge clk);
    check_eq("abort_pre", {29'd0, cs_n, wr_n, ad_oe}, 32'h1);
    reset = 1'b1; escribe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_strobes", {26'd0, cs_n, rd_n, wr_n, ad_oe, fin, ocupado}, 32'h38);
    check_eq("abort_dato", {24'd0, dato_leido}, 32'h00);
    exp_dato = 8'h00;
    reset = 1'b0;
    repeat (4*P+4) begin
      @(negedge clk);
      check_eq("abort_nofin", {30'd0, fin, cs_n}, 32'h1);
    end

    run_txn(1'b1, 1'b0, 8'h24, 8'h31, 8'h00, 1'b1, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 8'h24, 8'h31, 8'h00, 1'b1, 1'b0, 1'b1);
    run_txn(1'b1, 1'b0, 8'h24, 8'h31, 8'h00, 1'b0, 1'b0, 1'b1);

    run_txn(1'b1, 1'b0, 8'h21, 8'h59, 8'h00, 1'b0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b0, 8'h26, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
